// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants, FSM state type and CRC-8 step
//
// Contents:
//   state_t    : receiver FSM states IDLE, SHIFT, CHECK, DONE
//   FRAME_BITS : bits per frame (payload + CRC)
//   DATA_BITS  : payload bits
//   CRC_BITS   : CRC width
//   CRC8_POLY  : default generator polynomial
//   CRC8_INIT  : default CRC seed
//   crc8_step  : one MSB-first CRC-8 update, shared with the SPI master
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FRAME_BITS = 32;
    localparam int DATA_BITS  = 24;
    localparam int CRC_BITS   = 8;

    localparam logic [CRC_BITS-1:0] CRC8_POLY = 8'h1D;
    localparam logic [CRC_BITS-1:0] CRC8_INIT = 8'hFF;

    function automatic logic [CRC_BITS-1:0] crc8_step(
        input logic [CRC_BITS-1:0] crc,
        input logic                bit_in,
        input logic [CRC_BITS-1:0] poly = CRC8_POLY
    );
        logic fb;
        fb = crc[CRC_BITS-1] ^ bit_in;
        return {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchroniser with rise/fall pulse outputs
//
// Ports:
//   clk  in  : local clock
//   rstn in  : asynchronous active-low reset
//   d    in  : asynchronous input
//   q    out : synchronised level
//   rise out : one-cycle pulse on a synchronised 0->1 transition
//   fall out : one-cycle pulse on a synchronised 1->0 transition
//
// All stages reset to 0. For csn this means a reset taken while csn is held
// low produces no falling edge afterwards, so a frame interrupted by reset
// is not resumed; the next frame needs a fresh csn fall.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_crc_rx.sv
// rtl/spi_slave_crc_rx.sv - SPI slave receiving 24-bit payload + CRC-8 frames
//
// Ports:
//   clk         in  : system clock, at least 4x sck
//   rstn        in  : asynchronous active-low reset
//   sck         in  : SPI clock, CPOL=0
//   csn         in  : chip select, active low
//   mosi        in  : master data, sampled on sck fall
//   miso        out : slave data, updated on sck rise
//   out_data    out : received payload
//   out_crc_ok  out : received CRC matches locally computed CRC
//   out_valid   out : out_data/out_crc_ok valid
//   out_ready   in  : downstream accept
//   frame_abort out : pulse, csn rose before a full frame
//   overflow    out : pulse, completed frame dropped (output still full)
//
// Optional feature macro SPI_SLAVE_CRC_RX_MISO_EN: when defined, miso returns
// the last accepted payload with its CRC; otherwise miso is tied low.
module spi_slave_crc_rx
    import spi_pkg::*;
#(
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CRC_BITS-1:0] CRC_POLY    = CRC8_POLY,
    parameter logic [CRC_BITS-1:0] CRC_INIT    = CRC8_INIT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sck,
    input  logic                 csn,
    input  logic                 mosi,
    output logic                 miso,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_crc_ok,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_abort,
    output logic                 overflow
);

    localparam logic [5:0] DATA_CNT = 6'(DATA_BITS);
    localparam logic [5:0] LAST_CNT = 6'(FRAME_BITS - 1);

    logic sck_s, sck_rise, sck_fall;
    logic csn_s, csn_rise, csn_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rstn(rstn), .d(sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_csn (
        .clk(clk), .rstn(rstn), .d(csn), .q(csn_s), .rise(csn_rise), .fall(csn_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rstn(rstn), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    state_t                 state_q, state_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [CRC_BITS-1:0]    crc_q, crc_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]   out_data_q, out_data_d;
    logic                   out_crc_ok_q, out_crc_ok_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_abort_q, frame_abort_d;
    logic                   overflow_q, overflow_d;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        crc_d         = crc_q;
        shift_d       = shift_q;
        out_data_d    = out_data_q;
        out_crc_ok_d  = out_crc_ok_q;
        out_valid_d   = out_valid_q;
        frame_abort_d = 1'b0;
        overflow_d    = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A csn fall restarts reception from any state; only a started
        // frame in SHIFT counts as aborted.
        if (csn_fall) begin
            if (state_q == SHIFT && bit_cnt_q != '0) begin
                frame_abort_d = 1'b1;
            end
            state_d   = SHIFT;
            bit_cnt_d = '0;
            crc_d     = CRC_INIT;
        end else begin
            case (state_q)
                IDLE: ;
                SHIFT: begin
                    if (csn_rise) begin
                        frame_abort_d = 1'b1;
                        state_d       = IDLE;
                    end else if (sck_fall && !csn_s) begin
                        shift_d   = {shift_q[FRAME_BITS-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q < DATA_CNT) begin
                            crc_d = crc8_step(crc_q, mosi_s, CRC_POLY);
                        end
                        if (bit_cnt_q == LAST_CNT) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (out_valid_q && !out_ready) begin
                        overflow_d = 1'b1;
                    end else begin
                        out_data_d   = shift_q[FRAME_BITS-1:CRC_BITS];
                        out_crc_ok_d = (shift_q[CRC_BITS-1:0] == crc_q);
                        out_valid_d  = 1'b1;
                    end
                    state_d = csn_rise ? IDLE : DONE;
                end
                DONE: begin
                    if (csn_rise) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            crc_q         <= CRC_INIT;
            shift_q       <= '0;
            out_data_q    <= '0;
            out_crc_ok_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            crc_q         <= crc_d;
            shift_q       <= shift_d;
            out_data_q    <= out_data_d;
            out_crc_ok_q  <= out_crc_ok_d;
            out_valid_q   <= out_valid_d;
            frame_abort_q <= frame_abort_d;
            overflow_q    <= overflow_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_crc_ok  = out_crc_ok_q;
    assign out_valid   = out_valid_q;
    assign frame_abort = frame_abort_q;
    assign overflow    = overflow_q;

`ifdef SPI_SLAVE_CRC_RX_MISO_EN
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_BITS-1:0]  acc_data_q, acc_data_d;
    logic                  acc_seen_q, acc_seen_d;

    function automatic logic [CRC_BITS-1:0] crc_of(input logic [DATA_BITS-1:0] d);
        logic [CRC_BITS-1:0] c;
        c = CRC_INIT;
        for (int i = DATA_BITS - 1; i >= 0; i--) begin
            c = crc8_step(c, d[i], CRC_POLY);
        end
        return c;
    endfunction

    always_comb begin
        tx_d       = tx_q;
        acc_data_d = acc_data_q;
        acc_seen_d = acc_seen_q;
        if (out_valid_q && out_ready) begin
            acc_data_d = out_data_q;
            acc_seen_d = 1'b1;
        end
        // Bit 31 is already on miso from csn fall, so the first sck rise
        // (bit_cnt still 0) must not shift; each later rise presents the
        // bit the master samples on the following fall.
        if (csn_fall) begin
            tx_d = acc_seen_q ? {acc_data_q, crc_of(acc_data_q)} : '0;
        end else if (state_q == SHIFT && sck_rise && bit_cnt_q != '0) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_q       <= '0;
            acc_data_q <= '0;
            acc_seen_q <= 1'b0;
        end else begin
            tx_q       <= tx_d;
            acc_data_q <= acc_data_d;
            acc_seen_q <= acc_seen_d;
        end
    end

    assign miso         = tx_q[FRAME_BITS-1];
    assign unused_edges = mosi_rise ^ mosi_fall;
`else
    assign miso         = 1'b0;
    assign unused_edges = mosi_rise ^ mosi_fall ^ sck_rise;
`endif

endmodule

// File: tb/tb_spi_slave_crc_rx.sv
// tb/tb_spi_slave_crc_rx.sv - scoreboard bench for spi_slave_crc_rx
module tb_spi_slave_crc_rx;

    logic        clk;
    logic        rstn;
    logic        sck;
    logic        csn;
    logic        mosi;
    logic        miso;
    logic [23:0] out_data;
    logic        out_crc_ok;
    logic        out_valid;
    logic        out_ready;
    logic        frame_abort;
    logic        overflow;

    spi_slave_crc_rx dut (
        .clk(clk), .rstn(rstn), .sck(sck), .csn(csn), .mosi(mosi), .miso(miso),
        .out_data(out_data), .out_crc_ok(out_crc_ok), .out_valid(out_valid),
        .out_ready(out_ready), .frame_abort(frame_abort), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [23:0] data;
        logic        ok;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    int          abort_cnt = 0;
    int          ovf_cnt = 0;
    logic        held = 1'b0;
    logic [23:0] held_data;
    logic        held_ok;
    logic [31:0] miso_cap;

    function automatic logic [7:0] model_crc(input logic [23:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 23; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h1D;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Output monitor: stability while stalled, scoreboard on handshake.
    always @(negedge clk) begin
        if (rstn) begin
            if (frame_abort) abort_cnt++;
            if (overflow)    ovf_cnt++;
            if (out_valid) begin
                if (held) begin
                    total++;
                    if ({out_data, out_crc_ok} !== {held_data, held_ok}) begin
                        bad++;
                        $display("FAIL hold_stable got=%h/%b want=%h/%b", out_data, out_crc_ok, held_data, held_ok);
                    end
                end
                if (out_ready) begin
                    held = 1'b0;
                    acc_cnt++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_output got=%h/%b want=none", out_data, out_crc_ok);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if ({out_data, out_crc_ok} !== {e.data, e.ok}) begin
                            bad++;
                            $display("FAIL output got=%h/%b want=%h/%b", out_data, out_crc_ok, e.data, e.ok);
                        end
                    end
                end else begin
                    held      = 1'b1;
                    held_data = out_data;
                    held_ok   = out_crc_ok;
                end
            end else begin
                held = 1'b0;
            end
        end else begin
            held = 1'b0;
        end
    end

    // clk/8 sck: 4 clk high, 4 clk low. rst_at >= 0 pulses rstn before that bit.
    task automatic send_bits(input logic [39:0] vec, input int nbits, input int rst_at);
        @(negedge clk);
        csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rstn = 1'b0;
                @(posedge clk); #1;
                total++;
                if ({miso, out_data, out_crc_ok, out_valid, frame_abort, overflow} !== 29'd0) begin
                    bad++;
                    $display("FAIL mid_reset_outputs got=%h want=0",
                             {miso, out_data, out_crc_ok, out_valid, frame_abort, overflow});
                end
                @(negedge clk);
                rstn = 1'b1;
            end
            mosi = vec[nbits-1-i];
            sck  = 1'b1;
            repeat (4) @(negedge clk);
            miso_cap = {miso_cap[30:0], miso};
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        csn = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0; sck = 1'b0; csn = 1'b1; mosi = 1'b0; out_ready = 1'b1;
        miso_cap = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (miso !== 1'b0)        begin bad++; $display("FAIL rst_miso got=%b want=0", miso); end
        total++; if (out_data !== 24'd0)   begin bad++; $display("FAIL rst_data got=%h want=0", out_data); end
        total++; if (out_crc_ok !== 1'b0)  begin bad++; $display("FAIL rst_crc_ok got=%b want=0", out_crc_ok); end
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (frame_abort !== 1'b0) begin bad++; $display("FAIL rst_abort got=%b want=0", frame_abort); end
        total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good_frame;
        int a0, b0;
        a0 = acc_cnt; b0 = abort_cnt;
        exp_q.push_back('{24'hA5A5A5, 1'b1});
        send_bits({8'h00, 24'hA5A5A5, model_crc(24'hA5A5A5)}, 32, -1);
        total++; if (acc_cnt !== a0 + 1) begin bad++; $display("FAIL good_count got=%0d want=%0d", acc_cnt, a0 + 1); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL good_pending got=%0d want=0", exp_q.size()); end
        total++; if (abort_cnt !== b0)   begin bad++; $display("FAIL good_abort got=%0d want=%0d", abort_cnt, b0); end
    endtask

    task automatic test_bad_crc;
        int a0, b0;
        a0 = acc_cnt; b0 = abort_cnt;
        exp_q.push_back('{24'hA5A5A5, 1'b0});
        send_bits({8'h00, 24'hA5A5A5, model_crc(24'hA5A5A5) ^ 8'h01}, 32, -1);
        total++; if (acc_cnt !== a0 + 1) begin bad++; $display("FAIL badcrc_count got=%0d want=%0d", acc_cnt, a0 + 1); end
        total++; if (abort_cnt !== b0)   begin bad++; $display("FAIL badcrc_abort got=%0d want=%0d", abort_cnt, b0); end
    endtask

    task automatic test_abort;
        int a0, b0;
        a0 = acc_cnt; b0 = abort_cnt;
        send_bits({8'h00, 24'hA5A5A5, model_crc(24'hA5A5A5)}, 17, -1);
        total++; if (abort_cnt !== b0 + 1) begin bad++; $display("FAIL abort_pulse got=%0d want=%0d", abort_cnt, b0 + 1); end
        total++; if (acc_cnt !== a0)       begin bad++; $display("FAIL abort_output got=%0d want=%0d", acc_cnt, a0); end
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL abort_valid got=%b want=0", out_valid); end
        exp_q.push_back('{24'hA5A5A5, 1'b1});
        send_bits({8'h00, 24'hA5A5A5, model_crc(24'hA5A5A5)}, 32, -1);
        total++; if (acc_cnt !== a0 + 1)   begin bad++; $display("FAIL after_abort got=%0d want=%0d", acc_cnt, a0 + 1); end
    endtask

    task automatic test_overflow;
        int o0;
        o0 = ovf_cnt;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_q.push_back('{24'h123456, 1'b1});
        send_bits({8'h00, 24'h123456, model_crc(24'h123456)}, 32, -1);
        send_bits({8'h00, 24'hA5A5A5, model_crc(24'hA5A5A5)}, 32, -1);
        total++; if (ovf_cnt !== o0 + 1)       begin bad++; $display("FAIL ovf_pulse got=%0d want=%0d", ovf_cnt, o0 + 1); end
        total++; if (out_valid !== 1'b1)       begin bad++; $display("FAIL ovf_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 24'h123456)  begin bad++; $display("FAIL ovf_data got=%h want=123456", out_data); end
        total++; if (exp_q.size() !== 1)       begin bad++; $display("FAIL ovf_pending got=%0d want=1", exp_q.size()); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (exp_q.size() !== 0)       begin bad++; $display("FAIL ovf_drain got=%0d want=0", exp_q.size()); end
        total++; if (out_valid !== 1'b0)       begin bad++; $display("FAIL ovf_clear got=%b want=0", out_valid); end
    endtask

    task automatic test_long_frame;
        int a0;
        a0 = acc_cnt;
        exp_q.push_back('{24'hA5A5A5, 1'b1});
        send_bits({24'hA5A5A5, model_crc(24'hA5A5A5), 8'h5A}, 40, -1);
        total++; if (acc_cnt !== a0 + 1)  begin bad++; $display("FAIL long_count got=%0d want=%0d", acc_cnt, a0 + 1); end
        total++; if (exp_q.size() !== 0)  begin bad++; $display("FAIL long_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int a0, b0;
        a0 = acc_cnt; b0 = abort_cnt;
        send_bits({8'h00, 24'h123456, model_crc(24'h123456)}, 32, 10);
        total++; if (acc_cnt !== a0)     begin bad++; $display("FAIL rstmid_output got=%0d want=%0d", acc_cnt, a0); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
        total++; if (abort_cnt !== b0)   begin bad++; $display("FAIL rstmid_abort got=%0d want=%0d", abort_cnt, b0); end
    endtask

`ifdef SPI_SLAVE_CRC_RX_MISO_EN
    task automatic test_miso;
        exp_q.push_back('{24'hA5A5A5, 1'b1});
        send_bits({8'h00, 24'hA5A5A5, model_crc(24'hA5A5A5)}, 32, -1);
        exp_q.push_back('{24'h123456, 1'b1});
        miso_cap = '0;
        send_bits({8'h00, 24'h123456, model_crc(24'h123456)}, 32, -1);
        total++;
        if (miso_cap !== {24'hA5A5A5, model_crc(24'hA5A5A5)}) begin
            bad++;
            $display("FAIL miso_frame got=%h want=%h", miso_cap, {24'hA5A5A5, model_crc(24'hA5A5A5)});
        end
    endtask
`endif

    initial begin
        test_reset;
        test_good_frame;
        test_bad_crc;
        test_abort;
        test_overflow;
        test_long_frame;
        test_reset_mid;
`ifdef SPI_SLAVE_CRC_RX_MISO_EN
        test_miso;
`endif
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL final_pending got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_crc_rx.md
Name: spi_slave_crc_rx

Overview:
- Receive-side SPI slave that consumes the 32-bit frames produced by the team's SPI master.
- Frame format: 24-bit payload, then CRC-8 (poly 0x1D, init 0xFF), MSB first.
- Oversamples sck/csn/mosi in the local clk domain, deserialises the frame and checks the CRC.
- Delivers payload plus CRC status downstream over a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, synchroniser flops on sck, csn and mosi (minimum 2)
CRC_POLY, 8'h1D, CRC-8 generator polynomial
CRC_INIT, 8'hFF, CRC register value at frame start

Ports:
clk  in  1  system clock; must be at least 4x sck frequency
rstn  in  1  asynchronous, active-low reset
sck  in  1  SPI clock from master, CPOL=0, idle low
csn  in  1  chip select from master, active low
mosi  in  1  master data; master drives it on sck rise, this block samples it on sck fall
miso  out  1  slave data, updated on sck rise
out_data  out  24  received payload
out_crc_ok  out  1  1 = received CRC byte equals the locally computed CRC
out_valid  out  1  out_data/out_crc_ok valid
out_ready  in  1  downstream accept
frame_abort  out  1  one-cycle pulse: csn rose before 32 bits were received
overflow  out  1  one-cycle pulse: a completed frame was dropped because the output register was still full

Behaviour:
- Reset values: miso=0, out_data=0, out_crc_ok=0, out_valid=0, frame_abort=0, overflow=0; state=IDLE, bit_cnt=0, crc=CRC_INIT.
- Synchronisation and edge detection:
  - sck, csn and mosi each pass through SYNC_STAGES flops.
  - Falling/rising edges are detected from the last two synchronised samples.
  - All logic runs on clk only; no logic is clocked by sck.
- State machine:
  - IDLE: on detecting the synced csn falling edge, set bit_cnt=0 and crc=CRC_INIT, then go to SHIFT.
  - SHIFT, on each sck fall while csn is low:
    - shift mosi into shift_reg[31:0] LSB-side; bit_cnt++.
    - for bit_cnt<24: fb = crc[7]^mosi; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
    - when bit_cnt reaches 32, go to CHECK.
  - SHIFT, synced csn rises with bit_cnt<32: pulse frame_abort, discard the partial frame, go to IDLE.
  - CHECK, one cycle:
    - if out_valid && !out_ready: pulse overflow and drop the new frame.
    - otherwise load out_data=shift_reg[31:8], out_crc_ok=(shift_reg[7:0]==crc) and set out_valid.
    - then go to DONE.
  - DONE: ignore further sck edges (bits beyond 32 are discarded); on synced csn rise go to IDLE.
- Latency: out_valid asserts 1 clk after the cycle in which the 32nd sck fall is detected.
- Handshake:
  - out_valid is held, with out_data and out_crc_ok stable, until a cycle with out_valid && out_ready.
  - On that cycle out_valid clears, unless CHECK loads a new frame in the same cycle; then out_valid stays 1 with the new data.
- csn falling edge in any state other than IDLE (glitch or back-to-back frame): restart at SHIFT with bit_cnt=0 and crc=CRC_INIT. No abort pulse unless SHIFT was active with bit_cnt>0.
- Reset mid-frame: everything returns to reset values immediately; the next frame starts only after a fresh csn fall.

Optional Feature:
- Macro: SPI_SLAVE_CRC_RX_MISO_EN.
- Defined:
  - at csn fall, tx_reg loads {last accepted out_data, its 8-bit CRC recomputed with the same polynomial};
  - miso drives tx_reg[31] and shifts left on each sck rise while in SHIFT;
  - before the first accepted frame, tx_reg = 0.
- Undefined: miso is tied to 0 and no tx_reg is built.

Decomposition:
- Shared package spi_pkg:
  - state typedef (IDLE, SHIFT, CHECK, DONE);
  - constants FRAME_BITS=32, DATA_BITS=24, CRC_BITS=8, CRC8_POLY=8'h1D, CRC8_INIT=8'hFF;
  - function crc8_step(crc, bit), shared with the master.
- One sub-module, spi_sync_edge: N-stage synchroniser plus rise/fall pulse outputs, instantiated once each for sck, csn and mosi.

Test Plan:
- Frame 0xA5A5A5_62 at clk/8 sck, out_ready=1 -> one out_valid pulse, out_data=24'hA5A5A5, out_crc_ok=1.
- Frame 0xA5A5A5_63 -> out_data=24'hA5A5A5, out_crc_ok=0, no frame_abort.
- csn raised after 17 bits -> frame_abort pulses once, out_valid stays 0; next full frame 0xA5A5A5_62 is received correctly.
- out_ready=0, two good frames 0x123456+crc then 0xA5A5A5_62 -> first held stable, overflow pulses once, out_data stays 24'h123456 until accepted.
- 40 sck clocks within one csn-low window carrying 0xA5A5A5_62 plus 8 junk bits -> single output 24'hA5A5A5 with crc_ok=1; rstn pulse at bit 10 of a following frame -> all outputs reset, no output.
- With SPI_SLAVE_CRC_RX_MISO_EN, after accepting 0xA5A5A5 -> next frame's miso bits 31..0 = 0xA5A5A562.
